// File: rtl/pwm_multichannel_pkg.sv
// Shared constants and types for the multichannel PWM block.
// Imported by the interface, the timebase and the top.
package pwm_multichannel_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 11;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_multichannel_if.sv
// Configuration, duty-write and output bundle of the PWM block.
// master = register file side, slave = PWM core.
interface pwm_multichannel_if
  import pwm_multichannel_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [PRESC_W-1:0] prescale;
  logic [CNT_W-1:0]   period;
  logic               mode_center;
  logic [NUM_CH-1:0]  en_out;
  logic [NUM_CH-1:0]  en_pwm;
  logic               duty_wr_en;
  logic [CH_W-1:0]    duty_wr_ch;
  logic [CNT_W-1:0]   duty_wr_data;
  logic               period_start;
  logic [NUM_CH-1:0]  out;

  modport master (
    output prescale, period, mode_center,
    output en_out, en_pwm,
    output duty_wr_en, duty_wr_ch, duty_wr_data,
    input  period_start, out
  );

  modport slave (
    input  prescale, period, mode_center,
    input  en_out, en_pwm,
    input  duty_wr_en, duty_wr_ch, duty_wr_data,
    output period_start, out
  );

endinterface

// File: rtl/pwm_multichannel_timebase.sv
// Prescaler plus edge/center-aligned period counter.
// Period, prescale and mode are latched only at period boundaries.
module pwm_multichannel_timebase
  import pwm_multichannel_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   period,
  input  logic               mode_center,
  output logic [CNT_W-1:0]   cnt,
  output logic [CNT_W-1:0]   act_period,
  output logic               boundary,
  output logic               period_start
);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] act_presc;
  logic               act_mode;
  dir_e               dir;
  dir_e               dir_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               tick;

  assign tick = (presc_cnt == act_presc);

  always_comb begin
    cnt_nx = cnt + CNT_W'(1);
    dir_nx = dir;
    unique case (1'b1)
      (act_mode == MODE_EDGE): begin
        if (cnt >= act_period) cnt_nx = '0;
      end
      (act_mode == MODE_CENTER) && (dir == DIR_UP): begin
        if (cnt >= act_period) begin
          cnt_nx = (act_period == '0) ? '0
                 : act_period - CNT_W'(1);
          dir_nx = DIR_DOWN;
        end
      end
      default: begin
        cnt_nx = cnt - CNT_W'(1);
      end
    endcase
    // The boundary is the tick that brings the count back to zero.
    boundary = tick & (cnt_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      act_period   <= period;
      act_presc    <= prescale;
      act_mode     <= mode_center;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      presc_cnt    <= tick ? '0 : presc_cnt + PRESC_W'(1);
      if (boundary) begin
        cnt        <= '0;
        dir        <= DIR_UP;
        act_period <= period;
        act_presc  <= prescale;
        act_mode   <= mode_center;
      end else if (tick) begin
        cnt <= cnt_nx;
        dir <= dir_nx;
      end
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM with double-buffered per-channel duty.
// Shadow duty moves to active at each period boundary.
module pwm_multichannel
  import pwm_multichannel_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input logic              clk,
  input logic              rst_n,
  pwm_multichannel_if.slave bus
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  act_period;
  logic              boundary;
  logic [NUM_CH-1:0] hi;

  pwm_multichannel_timebase #(
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .prescale    (bus.prescale),
    .period      (bus.period),
    .mode_center (bus.mode_center),
    .cnt         (cnt),
    .act_period  (act_period),
    .boundary    (boundary),
    .period_start(bus.period_start)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic             wr;

    // Indices at or above NUM_CH match no channel and are dropped.
    assign wr = bus.duty_wr_en
              & (bus.duty_wr_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (wr) shadow <= bus.duty_wr_data;
        if (boundary) begin
          active <= wr ? bus.duty_wr_data : shadow;
        end
      end
    end

    assign hi[i] = (&active)
                 | (active > act_period)
                 | (cnt < active);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out <= '0;
    end else begin
      bus.out <= bus.en_out & (~bus.en_pwm | hi);
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomized scoreboard bench for pwm_multichannel.
// A phase-based reference model predicts out/period_start every clock.
module tb_pwm_multichannel;
  import pwm_multichannel_pkg::*;

  localparam int NUM_CH  = 12;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 11;
  localparam int ALL1    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multichannel_if #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)
  ) bus ();

  pwm_multichannel #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] out;
    logic              ps;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int passes = 0;

  // Reference model: position within the period as a plain phase index.
  int m_pc, m_phase, m_p, m_pr, m_mode;
  int m_sh[NUM_CH];
  int m_act[NUM_CH];

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s at %0t: got %h expected %h",
                  nm, $time, got, want);
  endfunction

  function automatic int cnt_of(input int ph);
    if (m_mode == 0 || ph <= m_p) return ph;
    return 2 * m_p - ph;
  endfunction

  function automatic int period_len(input int p, input int md);
    if (md != 0) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  // Predict the response of the coming posedge, then advance the model.
  task automatic step();
    exp_t e;
    int   c, d, len;
    bit   tick, bnd, h;
    e = '0;
    if (!rst_n) begin
      m_pc = 0;
      m_phase = 0;
      m_p = int'(bus.period);
      m_pr = int'(bus.prescale);
      m_mode = int'(bus.mode_center);
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh[i] = 0;
        m_act[i] = 0;
      end
    end else begin
      c = cnt_of(m_phase);
      for (int i = 0; i < NUM_CH; i++) begin
        d = m_act[i];
        h = (d == ALL1) || (d > m_p) || (c < d);
        e.out[i] = bus.en_out[i] && (!bus.en_pwm[i] || h);
      end
      tick = (m_pc == m_pr);
      len = period_len(m_p, m_mode);
      bnd = tick && (m_phase == len - 1);
      e.ps = bnd;
      if (bus.duty_wr_en && int'(bus.duty_wr_ch) < NUM_CH)
        m_sh[bus.duty_wr_ch] = int'(bus.duty_wr_data);
      if (tick) begin
        m_pc = 0;
        m_phase = bnd ? 0 : m_phase + 1;
      end else begin
        m_pc++;
      end
      if (bnd) begin
        m_act = m_sh;
        m_p = int'(bus.period);
        m_pr = int'(bus.prescale);
        m_mode = int'(bus.mode_center);
      end
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("out", 32'(bus.out), 32'(mon_e.out));
      chk("period_start", 32'(bus.period_start), 32'(mon_e.ps));
    end
  end

  // Reset, program one channel, settle, then count highs and boundaries.
  task automatic directed(input string nm, input int presc, input int p,
                          input int md, input int ch, input int duty,
                          input bit eo, input bit ep, input int cyc,
                          input int exp_hi, input int exp_ps);
    int hi_n, ps_n, settle;
    rst_n = 1'b0;
    bus.prescale = PRESC_W'(presc);
    bus.period = CNT_W'(p);
    bus.mode_center = md[0];
    bus.en_out = '1;
    bus.en_pwm = '1;
    bus.en_out[ch] = eo;
    bus.en_pwm[ch] = ep;
    bus.duty_wr_en = 1'b0;
    step();
    rst_n = 1'b1;
    bus.duty_wr_en = 1'b1;
    bus.duty_wr_ch = 4'(ch);
    bus.duty_wr_data = CNT_W'(duty);
    step();
    bus.duty_wr_en = 1'b0;
    settle = 2 * (presc + 1) * period_len(p, md) + 4;
    repeat (settle) step();
    hi_n = 0;
    ps_n = 0;
    repeat (cyc) begin
      step();
      hi_n += int'(bus.out[ch]);
      ps_n += int'(bus.period_start);
    end
    chk({nm, "_high"}, 32'(hi_n), 32'(exp_hi));
    chk({nm, "_starts"}, 32'(ps_n), 32'(exp_ps));
  endtask

  initial begin
    bus.prescale = '0;
    bus.period = 8'd9;
    bus.mode_center = MODE_EDGE;
    bus.en_out = '1;
    bus.en_pwm = '1;
    bus.duty_wr_en = 1'b0;
    bus.duty_wr_ch = '0;
    bus.duty_wr_data = '0;
    rst_n = 1'b0;
    step();
    step();

    directed("edge_p9_d5", 0, 9, 0, 0, 5, 1, 1, 100, 50, 10);
    directed("duty0", 0, 9, 0, 1, 0, 1, 1, 100, 0, 10);
    directed("duty_gt_p", 0, 9, 0, 2, 12, 1, 1, 100, 100, 10);
    directed("full_p255", 0, 255, 0, 5, 255, 1, 1, 512, 512, 2);
    directed("center_p4", 0, 4, 1, 6, 2, 1, 1, 80, 30, 10);
    directed("static_hi", 0, 9, 0, 7, 5, 1, 0, 100, 100, 10);
    directed("out_off", 0, 9, 0, 8, 5, 0, 1, 100, 0, 10);
    directed("presc12", 12, 3, 0, 3, 2, 1, 1, 520, 260, 10);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5000) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 24) == 0) begin
        bus.prescale = ($urandom_range(0, 7) == 0)
                     ? 11'd12 : PRESC_W'($urandom_range(0, 3));
        bus.period = ($urandom_range(0, 15) == 0)
                   ? 8'd255 : CNT_W'($urandom_range(0, 12));
        bus.mode_center = $urandom_range(0, 1) != 0;
      end
      if ($urandom_range(0, 39) == 0) begin
        bus.en_out = NUM_CH'($urandom | $urandom);
        bus.en_pwm = NUM_CH'($urandom | $urandom);
      end
      bus.duty_wr_en = ($urandom_range(0, 3) == 0);
      bus.duty_wr_ch = 4'($urandom_range(0, 15));
      bus.duty_wr_data = ($urandom_range(0, 9) == 0)
                       ? 8'd255 : CNT_W'($urandom_range(0, 14));
      step();
    end
    bus.duty_wr_en = 1'b0;
    step();

    @(posedge clk);
    #2;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
